// File: rtl/softmax_argmax_if.sv
// Enable/ack handshake bundle between the softmax stage (master) and the
// argmax consumer (slave): the request, the packed float32 vector and the result.
interface softmax_argmax_if #(
   parameter int DATA_WIDTH = 32,
   parameter int inputNum   = 10,
   parameter int IDX_WIDTH  = 4
);
   logic                           enable;
   logic [DATA_WIDTH*inputNum-1:0] inputs;
   logic                           ack;
   logic [IDX_WIDTH-1:0]           class_idx;
   logic [DATA_WIDTH-1:0]          max_val;

   modport master (output enable, inputs, input ack, class_idx, max_val);
   modport slave  (input enable, inputs, output ack, class_idx, max_val);
endinterface

// File: rtl/softmax_argmax.sv
// Captures a packed float32 vector on request and scans it one element per
// cycle, reporting the index and bit pattern of the largest element.
module softmax_argmax #(
   parameter int DATA_WIDTH = 32,
   parameter int inputNum   = 10,
   parameter int IDX_WIDTH  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   softmax_argmax_if.slave  sm
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(inputNum - 1);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shadow_q [inputNum];
   logic [DATA_WIDTH-1:0] shadow_d [inputNum];
   logic [DATA_WIDTH-1:0] elem_in  [inputNum];
   logic [IDX_WIDTH-1:0]  run_idx_q, run_idx_d;
   logic [DATA_WIDTH-1:0] run_val_q, run_val_d;
   logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  ack_q, ack_d;
   logic [IDX_WIDTH-1:0]  class_idx_q, class_idx_d;
   logic [DATA_WIDTH-1:0] max_val_q, max_val_d;
   logic [DATA_WIDTH-1:0] cand_val;
   logic                  cand_gt;

   // Map IEEE-754 bit patterns onto an unsigned total order.
   function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] x);
      return x[DATA_WIDTH-1] ? ~x : (x ^ {1'b1, {(DATA_WIDTH-1){1'b0}}});
   endfunction

   for (genvar gi = 0; gi < inputNum; gi++) begin : g_unpack
      assign elem_in[gi] = sm.inputs[DATA_WIDTH*gi +: DATA_WIDTH];
   end

   assign cand_val = shadow_q[cnt_q];
   assign cand_gt  = order_key(cand_val) > order_key(run_val_q);

   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      run_idx_d   = run_idx_q;
      run_val_d   = run_val_q;
      cnt_d       = cnt_q;
      ack_d       = ack_q;
      class_idx_d = class_idx_q;
      max_val_d   = max_val_q;

      case (state_q)
         IDLE: begin
            ack_d = 1'b0;
            if (sm.enable) begin
               shadow_d  = elem_in;
               run_idx_d = '0;
               run_val_d = elem_in[0];
               cnt_d     = IDX_WIDTH'(1);
               if (inputNum == 1) begin
                  class_idx_d = '0;
                  max_val_d   = elem_in[0];
                  ack_d       = 1'b1;
                  state_d     = DONE;
               end else begin
                  state_d = SCAN;
               end
            end
         end
         SCAN: begin
            if (cand_gt) begin
               run_idx_d = cnt_q;
               run_val_d = cand_val;
            end
            // Publish on the edge that consumes the final element.
            if (cnt_q == LAST_IDX) begin
               class_idx_d = cand_gt ? cnt_q : run_idx_q;
               max_val_d   = cand_gt ? cand_val : run_val_q;
               ack_d       = 1'b1;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + IDX_WIDTH'(1);
            end
         end
         DONE: begin
            ack_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            ack_d   = 1'b0;
         end
      endcase

      // A dropped request abandons any partial scan but keeps the last result.
      if (!sm.enable) begin
         state_d     = IDLE;
         ack_d       = 1'b0;
         class_idx_d = class_idx_q;
         max_val_d   = max_val_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         run_idx_q   <= '0;
         run_val_q   <= '0;
         cnt_q       <= '0;
         ack_q       <= 1'b0;
         class_idx_q <= '0;
         max_val_q   <= '0;
         for (int i = 0; i < inputNum; i++) shadow_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         run_idx_q   <= run_idx_d;
         run_val_q   <= run_val_d;
         cnt_q       <= cnt_d;
         ack_q       <= ack_d;
         class_idx_q <= class_idx_d;
         max_val_q   <= max_val_d;
      end
   end

   assign sm.ack       = ack_q;
   assign sm.class_idx = class_idx_q;
   assign sm.max_val   = max_val_q;
endmodule
